// File: rtl/frame_rr_arbiter_if.sv
// Frame-stream bundle between N_PORT sources and the round-robin frame arbiter.
// master: sources and downstream consumer; slave: the arbiter itself.
interface frame_rr_arbiter_if #(
   parameter int N_PORT = 4,
   parameter int DW     = 32,
   parameter int ID_W   = 2,
   parameter int CNT_W  = 16
);
   logic [N_PORT-1:0]    i_req;
   logic [N_PORT-1:0]    o_gnt;
   logic [N_PORT-1:0]    i_sop;
   logic [N_PORT-1:0]    i_vld;
   logic [N_PORT-1:0]    i_eop;
   logic [N_PORT*DW-1:0] i_data;
   logic                 o_sop;
   logic                 o_vld;
   logic                 o_eop;
   logic [DW-1:0]        o_data;
   logic [ID_W-1:0]      o_owner;
   logic                 o_busy;
   logic [CNT_W-1:0]     o_frame_cnt;
   logic                 o_tmo;

   modport master (
      output i_req, i_sop, i_vld, i_eop, i_data,
      input  o_gnt, o_sop, o_vld, o_eop, o_data, o_owner, o_busy, o_frame_cnt, o_tmo
   );

   modport slave (
      input  i_req, i_sop, i_vld, i_eop, i_data,
      output o_gnt, o_sop, o_vld, o_eop, o_data, o_owner, o_busy, o_frame_cnt, o_tmo
   );
endinterface

// File: rtl/frame_rr_arbiter.sv
// Frame-granular round-robin share of one sop/vld/eop/data stream; FRAME_ARB_TIMEOUT_EN adds a BUSY watchdog.
// Grant 1 cycle after request, data forwarded at 1-cycle latency; no back-pressure, non-owner beats are dropped.
module frame_rr_arbiter #(
   parameter int N_PORT  = 4,
   parameter int DW      = 32,
   parameter int ID_W    = 2,
   parameter int CNT_W   = 16,
   parameter int TMO_CYC = 256
) (
   input logic               clk,
   input logic               rst,
   frame_rr_arbiter_if.slave bus
);
   localparam logic [0:0]        ST_IDLE = 1'b0;
   localparam logic [0:0]        ST_BUSY = 1'b1;
   localparam logic [N_PORT-1:0] ONE_HOT = N_PORT'(1);

   if (ID_W != $clog2(N_PORT)) begin : g_bad_id_w
      $error("frame_rr_arbiter: ID_W must equal clog2(N_PORT)");
   end
   if (N_PORT < 2 || N_PORT > 16 || TMO_CYC < 2) begin : g_bad_range
      $error("frame_rr_arbiter: N_PORT must be 2..16 and TMO_CYC at least 2");
   end

   logic [0:0]        state;
   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   owner;
   logic [N_PORT-1:0] gnt;
   logic              busy;
   logic              out_sop;
   logic              out_vld;
   logic              out_eop;
   logic [DW-1:0]     out_data;
   logic [CNT_W-1:0]  frame_cnt;

   logic [DW-1:0]     port_data [N_PORT];
   logic              own_sop;
   logic              own_vld;
   logic              own_eop;
   logic [DW-1:0]     own_data;

   logic [ID_W:0]     cand;
   logic              sel_found;
   logic [ID_W-1:0]   sel_idx;
   logic [ID_W-1:0]   ptr_next;

   for (genvar k = 0; k < N_PORT; k++) begin : g_unpack
      assign port_data[k] = bus.i_data[k*DW +: DW];
   end

   assign own_sop  = bus.i_sop[owner];
   assign own_vld  = bus.i_vld[owner];
   assign own_eop  = bus.i_eop[owner];
   assign own_data = port_data[owner];

   // First requester at or above rr_ptr, wrapping modulo N_PORT.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      for (int i = 0; i < N_PORT; i++) begin
         cand = {1'b0, rr_ptr} + (ID_W+1)'(i);
         if (cand >= (ID_W+1)'(N_PORT)) begin
            cand = cand - (ID_W+1)'(N_PORT);
         end
         if (!sel_found && bus.i_req[cand[ID_W-1:0]]) begin
            sel_found = 1'b1;
            sel_idx   = cand[ID_W-1:0];
         end
      end
   end

   assign ptr_next = (sel_idx == ID_W'(N_PORT-1)) ? '0 : sel_idx + ID_W'(1);

`ifdef FRAME_ARB_TIMEOUT_EN
   localparam int TMO_W = $clog2(TMO_CYC + 1);

   logic [TMO_W-1:0] tmo_cnt;
   logic             tmo;
   logic             tmo_hit;

   // Fires on the TMO_CYC-th BUSY cycle counted from the grant.
   assign tmo_hit   = (tmo_cnt == TMO_W'(TMO_CYC - 1));
   assign bus.o_tmo = tmo;
`else
   assign bus.o_tmo = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         rr_ptr    <= '0;
         owner     <= '0;
         gnt       <= '0;
         busy      <= 1'b0;
         out_sop   <= 1'b0;
         out_vld   <= 1'b0;
         out_eop   <= 1'b0;
         out_data  <= '0;
         frame_cnt <= '0;
`ifdef FRAME_ARB_TIMEOUT_EN
         tmo_cnt   <= '0;
         tmo       <= 1'b0;
`endif
      end else begin
         gnt <= '0;
`ifdef FRAME_ARB_TIMEOUT_EN
         tmo <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               out_sop  <= 1'b0;
               out_vld  <= 1'b0;
               out_eop  <= 1'b0;
               out_data <= '0;
               // busy stays up across back-to-back frames, drops one cycle after eop otherwise
               busy     <= sel_found;
               if (sel_found) begin
                  owner  <= sel_idx;
                  gnt    <= ONE_HOT << sel_idx;
                  rr_ptr <= ptr_next;
                  state  <= ST_BUSY;
`ifdef FRAME_ARB_TIMEOUT_EN
                  tmo_cnt <= '0;
`endif
               end
            end
            ST_BUSY: begin
               out_sop  <= own_vld & own_sop;
               out_vld  <= own_vld;
               out_eop  <= own_vld & own_eop;
               out_data <= own_vld ? own_data : '0;
               if (own_vld & own_eop) begin
                  frame_cnt <= frame_cnt + CNT_W'(1);
                  state     <= ST_IDLE;
               end
`ifdef FRAME_ARB_TIMEOUT_EN
               else if (tmo_hit) begin
                  // Close the frame downstream with an empty eop beat; not counted as a frame.
                  tmo      <= 1'b1;
                  out_sop  <= 1'b0;
                  out_vld  <= 1'b1;
                  out_eop  <= 1'b1;
                  out_data <= '0;
                  state    <= ST_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
               end
`endif
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.o_gnt       = gnt;
   assign bus.o_sop       = out_sop;
   assign bus.o_vld       = out_vld;
   assign bus.o_eop       = out_eop;
   assign bus.o_data      = out_data;
   assign bus.o_owner     = owner;
   assign bus.o_busy      = busy;
   assign bus.o_frame_cnt = frame_cnt;
endmodule

// File: tb/tb_frame_rr_arbiter.sv
// Bench for frame_rr_arbiter: directed frames from a source model feed a scoreboard queue;
// a negedge monitor pops and compares every grant and every forwarded beat.
`timescale 1ns/1ps
module tb_frame_rr_arbiter;
   localparam int N_PORT  = 4;
   localparam int DW      = 32;
   localparam int ID_W    = 2;
   localparam int CNT_W   = 3;
   localparam int TMO_CYC = 16;

   typedef struct {
      logic [DW-1:0]    data;
      logic             sop;
      logic             eop;
      logic [CNT_W-1:0] cnt;
      int               cyc;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   busy_cnt = 0;
   int   dead_seen = 0;
   int   tmo_seen = 0;
   int   last_gnt_cyc = 0;

   beat_t beat_q[$];
   int    gnt_q[$];

   // source model state, owned by the stimulus process
   int               frames_left [N_PORT];
   int               flen        [N_PORT];
   int               bidx        [N_PORT];
   int               abort_at    [N_PORT];
   bit               act         [N_PORT];
   bit               junk        [N_PORT];
   bit               no_eop      [N_PORT];
   bit               hold_rst;
   logic [CNT_W-1:0] exp_frames;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   frame_rr_arbiter_if #(.N_PORT(N_PORT), .DW(DW), .ID_W(ID_W), .CNT_W(CNT_W)) bus ();

   frame_rr_arbiter #(
      .N_PORT(N_PORT), .DW(DW), .ID_W(ID_W), .CNT_W(CNT_W), .TMO_CYC(TMO_CYC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic check(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
      checks++;
      if (act_v !== exp_v) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act_v, exp_v);
      end
   endtask

   // One clock of the source model: drive active frames, then react to a visible grant.
   task automatic tick();
      logic [N_PORT-1:0]    v, s, e, r;
      logic [N_PORT*DW-1:0] d;
      bit                   do_rst;
      beat_t                b;
      @(posedge clk);
      #1;
      v = '0; s = '0; e = '0; d = '0; do_rst = 1'b0;
      for (int p = 0; p < N_PORT; p++) begin
         if (act[p]) begin
            v[p] = 1'b1;
            s[p] = (bidx[p] == 0);
            e[p] = !no_eop[p] && (bidx[p] == flen[p] - 1);
            d[p*DW +: DW] = DW'(p * 256 + bidx[p]);
            if (abort_at[p] == bidx[p]) begin
               do_rst = 1'b1;
            end else begin
               if (e[p]) exp_frames = exp_frames + 1'b1;
               b.data = DW'(p * 256 + bidx[p]);
               b.sop  = s[p];
               b.eop  = e[p];
               b.cnt  = exp_frames;
               b.cyc  = cyc + 1;
               beat_q.push_back(b);
               bidx[p]++;
               if (bidx[p] == flen[p]) begin
                  act[p] = 1'b0;
                  if (no_eop[p]) begin
                     b.data = '0; b.sop = 1'b0; b.eop = 1'b1; b.cnt = exp_frames; b.cyc = 0;
                     beat_q.push_back(b);
                  end
               end
            end
         end else if (junk[p]) begin
            v[p] = 1'b1; s[p] = 1'b1; e[p] = 1'b1;
            d[p*DW +: DW] = DW'(32'hDEAD);
         end
      end
      if (do_rst) begin
         for (int p = 0; p < N_PORT; p++) act[p] = 1'b0;
         exp_frames = '0;
      end
      for (int p = 0; p < N_PORT; p++) begin
         if (bus.o_gnt[p]) begin
            act[p]  = 1'b1;
            bidx[p] = 0;
            if (frames_left[p] > 0) frames_left[p]--;
         end
         r[p] = (frames_left[p] > 0);
      end
      bus.i_req  = r;
      bus.i_sop  = s;
      bus.i_vld  = v;
      bus.i_eop  = e;
      bus.i_data = d;
      rst        = hold_rst | do_rst;
   endtask

   function automatic bit idle_all();
      bit ok;
      ok = (beat_q.size() == 0) && (gnt_q.size() == 0) && !bus.o_busy;
      for (int p = 0; p < N_PORT; p++) begin
         if (act[p] || frames_left[p] != 0) ok = 1'b0;
      end
      return ok;
   endfunction

   task automatic run(input int budget, input string name);
      int n;
      n = 0;
      tick();
      while (!idle_all() && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL %s: not drained after %0d cycles (beats left %0d, grants left %0d)",
                  name, n, beat_q.size(), gnt_q.size());
      end
   endtask

   // Monitor: every grant pulse and every forwarded beat must match the head of its queue.
   initial begin
      beat_t             e;
      int                eg;
      logic [N_PORT-1:0] exp_g;
      forever begin
         @(negedge clk);
         if (bus.o_busy) busy_cnt++;
         if (bus.o_vld && bus.o_data == DW'(32'hDEAD)) dead_seen++;
         if ((bus.o_sop || bus.o_eop) && !bus.o_vld) begin
            checks++; errors++;
            $display("FAIL framing: sop=%b eop=%b without vld at cycle %0d", bus.o_sop, bus.o_eop, cyc);
         end
         if (bus.o_gnt != '0) begin
            last_gnt_cyc = cyc;
            checks++;
            if (gnt_q.size() == 0) begin
               errors++;
               $display("FAIL grant: unexpected o_gnt=%b at cycle %0d", bus.o_gnt, cyc);
            end else begin
               eg    = gnt_q.pop_front();
               exp_g = N_PORT'(1) << eg;
               if (bus.o_gnt !== exp_g || bus.o_owner !== ID_W'(eg) || bus.o_busy !== 1'b1) begin
                  errors++;
                  $display("FAIL grant: got gnt=%b owner=%0d busy=%b expected gnt=%b owner=%0d busy=1",
                           bus.o_gnt, bus.o_owner, bus.o_busy, exp_g, eg);
               end
            end
         end
         if (bus.o_vld) begin
            checks++;
            if (beat_q.size() == 0) begin
               errors++;
               $display("FAIL beat: unexpected data=0x%0h at cycle %0d", bus.o_data, cyc);
            end else begin
               e = beat_q.pop_front();
               if (bus.o_data !== e.data || bus.o_sop !== e.sop || bus.o_eop !== e.eop ||
                   bus.o_frame_cnt !== e.cnt || bus.o_busy !== 1'b1 || (e.cyc != 0 && e.cyc != cyc)) begin
                  errors++;
                  $display("FAIL beat: got data=0x%0h sop=%b eop=%b cnt=%0d busy=%b cyc=%0d expected data=0x%0h sop=%b eop=%b cnt=%0d busy=1 cyc=%0d",
                           bus.o_data, bus.o_sop, bus.o_eop, bus.o_frame_cnt, bus.o_busy, cyc,
                           e.data, e.sop, e.eop, e.cnt, e.cyc);
               end
            end
         end
         if (bus.o_tmo) begin
            tmo_seen++;
            checks++;
`ifdef FRAME_ARB_TIMEOUT_EN
            if (cyc - last_gnt_cyc != TMO_CYC) begin
               errors++;
               $display("FAIL tmo_time: got grant+%0d expected grant+%0d", cyc - last_gnt_cyc, TMO_CYC);
            end
`else
            errors++;
            $display("FAIL tmo_tied: got o_tmo=1 expected 0 at cycle %0d", cyc);
`endif
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int b0, d0, t0, n;
      hold_rst   = 1'b1;
      exp_frames = '0;
      for (int p = 0; p < N_PORT; p++) begin
         frames_left[p] = 0; flen[p] = 1; bidx[p] = 0; abort_at[p] = -1;
         act[p] = 1'b0; junk[p] = 1'b0; no_eop[p] = 1'b0;
      end
      bus.i_req = '0; bus.i_sop = '0; bus.i_vld = '0; bus.i_eop = '0; bus.i_data = '0;

      // reset then idle: everything stays at zero
      repeat (2) tick();
      hold_rst = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick();
         check("idle_ctl", {bus.o_gnt, bus.o_sop, bus.o_vld, bus.o_eop, bus.o_busy,
                            bus.o_owner, bus.o_frame_cnt, bus.o_tmo}, 64'd0);
         check("idle_data", bus.o_data, 64'd0);
      end

      // all four request, 10-beat frames; port 0 comes back last
      for (int p = 0; p < N_PORT; p++) flen[p] = 10;
      frames_left[0] = 2; frames_left[1] = 1; frames_left[2] = 1; frames_left[3] = 1;
      gnt_q.push_back(0); gnt_q.push_back(1); gnt_q.push_back(2); gnt_q.push_back(3); gnt_q.push_back(0);
      run(400, "rr_frames");
      check("cnt_rr", bus.o_frame_cnt, 64'd5);

      // port 2 alone, single-beat frame
      flen[2] = 1; frames_left[2] = 1;
      gnt_q.push_back(2);
      b0 = busy_cnt;
      run(50, "single_beat");
      check("busy_len_single", 64'(busy_cnt - b0), 64'd3);
      check("cnt_single", bus.o_frame_cnt, 64'd6);

      // port 1 owns while port 3 sprays 0xDEAD beats without requesting
      junk[3] = 1'b1; flen[1] = 5; frames_left[1] = 1;
      gnt_q.push_back(1);
      d0 = dead_seen;
      run(50, "filter");
      junk[3] = 1'b0;
      check("dead_seen", 64'(dead_seen - d0), 64'd0);
      check("cnt_filter", bus.o_frame_cnt, 64'd7);

      // rr_ptr=2 with ports 0 and 3 requesting: 3 wins, then 0; counter wraps 7->0->1
      flen[0] = 1; flen[3] = 1; frames_left[0] = 1; frames_left[3] = 1;
      gnt_q.push_back(3); gnt_q.push_back(0);
      run(50, "wrap");
      check("cnt_wrap", bus.o_frame_cnt, 64'd1);

      // reset during beat 3 of port 2's 10-beat frame
      flen[2] = 10; abort_at[2] = 3; frames_left[2] = 1;
      gnt_q.push_back(2);
      n = 0;
      while (!rst && n < 100) begin
         tick();
         n++;
      end
      check("abort_reached", 64'(rst), 64'd1);
      tick();
      abort_at[2] = -1;
      check("rst_ctl", {bus.o_gnt, bus.o_sop, bus.o_vld, bus.o_eop, bus.o_busy, bus.o_frame_cnt}, 64'd0);
      check("rst_data", bus.o_data, 64'd0);

      // rr pointer back at 0: port 1 before port 3
      flen[1] = 1; flen[3] = 1; frames_left[1] = 1; frames_left[3] = 1;
      gnt_q.push_back(1); gnt_q.push_back(3);
      run(50, "post_rst");
      check("cnt_post_rst", bus.o_frame_cnt, 64'd2);

`ifdef FRAME_ARB_TIMEOUT_EN
      // port 0 sends sop only and never ends; watchdog closes it, then port 1 is served
      flen[0] = 1; no_eop[0] = 1'b1; frames_left[0] = 1;
      flen[1] = 1; frames_left[1] = 1;
      gnt_q.push_back(0); gnt_q.push_back(1);
      t0 = tmo_seen;
      run(200, "timeout");
      no_eop[0] = 1'b0;
      check("tmo_pulses", 64'(tmo_seen - t0), 64'd1);
      check("cnt_tmo", bus.o_frame_cnt, 64'd3);
`else
      t0 = tmo_seen;
      repeat (5) tick();
      check("tmo_none", 64'(tmo_seen - t0), 64'd0);
`endif

      check("queues_empty", 64'(beat_q.size() + gnt_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/frame_rr_arbiter.md
Name: frame_rr_arbiter

Overview:
- Shares one frame-stream output (sop/vld/data/eop) between N_PORT data_gen_wrapper-style sources, ahead of the cache write port.
- Round-robin, frame-granular: a granted port owns the output from grant until its eop beat. Interleaving of frames is impossible.
- Output is registered. A shared frame counter feeds frame_cnt-style checking.

Parameters:
- N_PORT, 4, number of requesting sources (2..16)
- DW, 32, data width
- ID_W, 2, width of grant index; must equal clog2(N_PORT)
- CNT_W, 16, width of forwarded-frame counter
- TMO_CYC, 256, watchdog limit in cycles (used only with the optional feature)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- i_req  in  N_PORT  per-port "frame ready" request, level
- o_gnt  out  N_PORT  one-hot grant pulse, exactly 1 cycle wide
- i_sop  in  N_PORT  per-port start of frame, qualified by i_vld
- i_vld  in  N_PORT  per-port beat valid
- i_eop  in  N_PORT  per-port end of frame, qualified by i_vld
- i_data  in  N_PORT*DW  packed data; port k occupies bits [k*DW +: DW]
- o_sop  out  1  forwarded sop
- o_vld  out  1  forwarded valid
- o_eop  out  1  forwarded eop
- o_data  out  DW  forwarded data
- o_owner  out  ID_W  index of current owner; meaningful while o_busy=1
- o_busy  out  1  high from the grant cycle through the cycle the eop beat is forwarded
- o_frame_cnt  out  CNT_W  frames forwarded since reset; wraps
- o_tmo  out  1  watchdog abort pulse; tied 0 without the optional feature

Behaviour:
- Reset (sampled rst=1 at edge) forces all outputs to 0, state IDLE, rr pointer 0, o_frame_cnt 0. Reset mid-frame abandons the frame: no eop is emitted, and the counter is cleared.
- State IDLE, when i_req != 0:
  - Select the first set bit searching from rr_ptr upward, wrapping modulo N_PORT.
  - Register owner, then assert o_gnt[owner] for one cycle on the next cycle (T+1). Set o_busy=1 from T+1.
  - Set rr_ptr = owner+1 (mod N_PORT). Go to BUSY.
- IDLE with i_req == 0: no grant, rr_ptr unchanged.
- State BUSY:
  - Each cycle, register output = owner's sop/vld/eop/data, gated with i_vld[owner]. Latency is 1 cycle; o_sop/o_eop are never high without o_vld.
  - All other ports' sop/vld/eop/data are ignored. Their beats are dropped and they receive no back-pressure.
  - When i_vld[owner] & i_eop[owner] is seen at edge T:
    - o_eop=1 at T+1; o_frame_cnt increments at T+1.
    - State returns to IDLE at T+1; o_busy falls at T+2.
    - The next grant pulse appears at T+2 at the earliest.
- Single-beat frame (sop & eop & vld on the same beat) counts as one frame and ends BUSY.
- A vld beat without a preceding sop while BUSY is forwarded unchanged; the arbiter does not check framing.
- i_req dropping after the grant has no effect; BUSY persists until eop.
- i_req for the owner staying high after eop makes it eligible again, but only after all other requesters in round-robin order.
- o_frame_cnt wraps from 2^CNT_W-1 to 0 with no flag.

Optional Feature:
- Macro FRAME_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on grant and increments each BUSY cycle.
  - If it reaches TMO_CYC with no owner eop, o_tmo pulses for 1 cycle and o_vld/o_eop are forced high with o_sop=0 and o_data=0. This closes the frame downstream.
  - o_frame_cnt is not incremented. State returns to IDLE.
  - The owner's later beats are ignored until it is granted again.
- Undefined: no counter is built, o_tmo is tied 0, and BUSY waits indefinitely.

Test Plan:
- rst held 2 cycles, then i_req=4'b0000 for 20 cycles -> all outputs 0, o_gnt never asserted, o_frame_cnt=0.
- i_req=4'b1111 held; each source sends a 10-beat frame (data = port*256+beat) starting 1 cycle after its grant -> grants in order 0,1,2,3,0; output data in contiguous per-port runs; o_frame_cnt=5 after the fifth eop.
- Port 2 requests alone with a 1-beat sop+eop frame -> o_gnt=4'b0100 for 1 cycle; exactly one output beat with sop=eop=vld=1; o_busy lasts 3 cycles total; count +1.
- While port 1 owns the output, port 3 drives vld beats with data 0xDEAD -> no 0xDEAD on o_data; port 1's 5 beats appear in order at 1-cycle latency.
- rst pulsed during beat 3 of a 10-beat frame -> outputs 0 the next cycle, o_frame_cnt=0, the next grant goes to the lowest requester from port 0.
- With FRAME_ARB_TIMEOUT_EN and TMO_CYC=16, the owner never sends eop -> o_tmo and a forced o_eop occur at grant+16 cycles; count unchanged; the next requester is granted afterwards.
